// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one byte-level UART transmitter between NUM_REQ requesters.
//   Round-robin arbitration at message granularity: the winner keeps the
//   transmitter until the byte flagged with req_last has been sent.
//   One o_tx_start pulse is issued per byte, paced on i_tx_busy.
//
// Parameters
//   NUM_REQ       number of requesters (>= 1)
//   IDLE_TIMEOUT  LOCKED-state clocks without a transfer before an idle owner
//                 is forcibly released (used only with ARB_TIMEOUT_EN)
//
// Optional feature macro: ARB_TIMEOUT_EN (idle-owner release counter)
//
// Ports
//   i_clk           system clock
//   i_rst_n         synchronous reset, active low
//   i_req_valid     requester i has a byte on i_req_data[8*i+:8]
//   i_req_data      packed byte per requester
//   i_req_last      byte of requester i ends its message
//   o_req_ready     one-hot accept strobe for the owner (LOCKED only)
//   o_tx_start      1-cycle pulse: transmitter latches o_tx_byte
//   o_tx_byte       byte to transmit, held until the next transfer
//   i_tx_busy       transmitter is framing a byte
//   o_grant_active  a requester currently owns the transmitter
//   o_grant_id      owner index, valid while o_grant_active=1
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_busy,
  output logic                 o_grant_active,
  output logic [IDW-1:0]       o_grant_id
);

  if (NUM_REQ < 1 || IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 65535) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be >= 1 and IDLE_TIMEOUT in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCKED,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [IDW-1:0] r_gid, w_gid_nxt;
  logic           r_tx_start, w_tx_start_nxt;
  logic [7:0]     r_tx_byte, w_tx_byte_nxt;
  logic           r_last, w_last_nxt;

  logic           w_found;
  logic [IDW-1:0] w_win;
  int unsigned    w_idx;
  logic [IDW-1:0] w_idx_n;
  logic [7:0]     w_gdata;
  logic           w_gvalid;
  logic           w_glast;
  logic [IDW-1:0] w_ptr_adv;

`ifdef ARB_TIMEOUT_EN
  logic [15:0]    r_idle_cnt, w_idle_cnt_nxt;
`endif

  // First valid requester at or after the pointer, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    w_idx_n = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = 32'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_idx_n = IDW'(w_idx);
      if (!w_found && i_req_valid[w_idx_n]) begin
        w_found = 1'b1;
        w_win   = w_idx_n;
      end
    end
  end

  // Owner's byte via a constant-index mux.
  always_comb begin
    w_gdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == r_gid) w_gdata = i_req_data[8*i +: 8];
    end
  end

  assign w_gvalid  = i_req_valid[r_gid];
  assign w_glast   = i_req_last[r_gid];
  assign w_ptr_adv = (r_gid == IDW'(NUM_REQ - 1)) ? '0 : r_gid + IDW'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_gid_nxt      = r_gid;
    w_tx_start_nxt = 1'b0;
    w_tx_byte_nxt  = r_tx_byte;
    w_last_nxt     = r_last;
    o_req_ready    = '0;
`ifdef ARB_TIMEOUT_EN
    w_idle_cnt_nxt = r_idle_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gid_nxt   = w_win;
          w_state_nxt = S_LOCKED;
`ifdef ARB_TIMEOUT_EN
          w_idle_cnt_nxt = '0;
`endif
        end
      end
      S_LOCKED: begin
        o_req_ready[r_gid] = !i_tx_busy;
        if (w_gvalid && !i_tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_tx_byte_nxt  = w_gdata;
          w_last_nxt     = w_glast;
          w_state_nxt    = S_WAIT_BUSY;
`ifdef ARB_TIMEOUT_EN
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt >= 16'(IDLE_TIMEOUT) && !w_gvalid) begin
          // Idle owner released exactly as if its last byte had gone out.
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = S_IDLE;
        end else if (r_idle_cnt < 16'(IDLE_TIMEOUT)) begin
          w_idle_cnt_nxt = r_idle_cnt + 16'd1;
`endif
        end
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (r_last) begin
            w_ptr_nxt   = w_ptr_adv;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_LOCKED;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_gid      <= '0;
      r_tx_start <= 1'b0;
      r_tx_byte  <= '0;
      r_last     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_idle_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gid      <= w_gid_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_last     <= w_last_nxt;
`ifdef ARB_TIMEOUT_EN
      r_idle_cnt <= w_idle_cnt_nxt;
`endif
    end
  end

  assign o_tx_start     = r_tx_start;
  assign o_tx_byte      = r_tx_byte;
  assign o_grant_active = (r_state != S_IDLE);
  assign o_grant_id     = r_gid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with a transmitter model, per-requester
// byte FIFOs and a scoreboard of expected {grant_id, byte} per tx_start pulse.
module tb_uart_tx_arbiter;
  localparam int N         = 4;
  localparam int BUSY_CLKS = 10;
  localparam int TMO       = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx_start;
  logic [7:0]     tx_byte;
  logic           tx_busy;
  logic           grant_active;
  logic [1:0]     grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(req_ready), .o_tx_start(tx_start), .o_tx_byte(tx_byte),
    .i_tx_busy(tx_busy), .o_grant_active(grant_active), .o_grant_id(grant_id)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Requester FIFOs: {last, byte}; heads advance on valid&ready, flushed by reset.
  logic [8:0] rmem  [N][16];
  logic [3:0] rhead [N];
  logic [3:0] rtail [N];
  logic       t1_all;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = t1_all | (rhead[i] != rtail[i]);
      req_data[8*i +: 8] = rmem[i][rhead[i]][7:0];
      req_last[i]        = rmem[i][rhead[i]][8];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) rhead[i] <= rtail[i];
      else if (req_valid[i] && req_ready[i]) rhead[i] <= rhead[i] + 4'd1;
    end
  end

  // Transmitter model: busy rises the cycle after tx_start, lasts BUSY_CLKS.
  int   busy_cnt;
  logic force_busy;
  always @(posedge clk) begin
    if (!rst_n) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= BUSY_CLKS;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt > 0) | force_busy;

  // Scoreboard
  logic [9:0] exp_q[$];
  logic [9:0] e;
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && tx_start === 1'b1) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
      n_total++;
      assert ({grant_id, tx_byte} === e) n_pass++;
      else begin
        n_fail++;
        $error("FAIL sb_tx: got id=%0d byte=0x%02h, want {id,byte}=0x%03h", grant_id, tx_byte, e);
      end
      n_total++;
      assert (prev_start === 1'b0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL tx_start_width: start high 2 cycles, got prev=%b, want 0", prev_start);
      end
    end
    prev_start = tx_start;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic req_push(input int id, input logic [7:0] b, input logic last);
    rmem[id][rtail[id]] = {last, b};
    rtail[id] = rtail[id] + 4'd1;
  endtask

  task automatic exp_push(input int id, input logic [7:0] b);
    exp_q.push_back({2'(id), b});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rhead[i] != rtail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag, input int maxc);
    int c = 0;
    while (!(grant_active === 1'b0 && tx_busy === 1'b0 && all_empty() && exp_q.size() == 0)
           && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_complete"}, 32'(c < maxc), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int  c;
    bit  ok;
    rst_n      = 1'b0;
    t1_all     = 1'b1;
    force_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      rtail[i] = '0;
      for (int j = 0; j < 16; j++) rmem[i][j] = '0;
    end

    // T1: reset with every requester valid
    repeat (3) @(negedge clk);
    check("t1_req_ready", 32'(req_ready), 32'd0);
    check("t1_tx_start", 32'(tx_start), 32'd0);
    check("t1_grant_active", 32'(grant_active), 32'd0);
    check("t1_tx_byte", 32'(tx_byte), 32'd0);
    check("t1_grant_id", 32'(grant_id), 32'd0);
    t1_all = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // T2: requester 2 sends "Hi"
    req_push(2, 8'h48, 1'b0);
    req_push(2, 8'h69, 1'b1);
    exp_push(2, 8'h48);
    exp_push(2, 8'h69);
    @(negedge clk);
    check("t2_grant_active", 32'(grant_active), 32'd1);
    check("t2_grant_id", 32'(grant_id), 32'd2);
    check("t2_req_ready", 32'(req_ready), 32'b0100);
    wait_idle("t2", 200);
    check("t2_idle_after", 32'(grant_active), 32'd0);

    // T3: round robin among 0,1,3 from pointer 0
    do_reset();
    req_push(0, 8'hA0, 1'b1);
    req_push(0, 8'hA1, 1'b1);
    req_push(1, 8'hB0, 1'b1);
    req_push(3, 8'hD0, 1'b1);
    exp_push(0, 8'hA0);
    exp_push(1, 8'hB0);
    exp_push(3, 8'hD0);
    exp_push(0, 8'hA1);
    wait_idle("t3", 400);

    // T4: message locking, requester 1 pending throughout
    do_reset();
    req_push(0, 8'h11, 1'b0);
    req_push(0, 8'h22, 1'b0);
    req_push(0, 8'h33, 1'b1);
    req_push(1, 8'h44, 1'b1);
    exp_push(0, 8'h11);
    exp_push(0, 8'h22);
    exp_push(0, 8'h33);
    exp_push(1, 8'h44);
    wait_idle("t4", 400);

    // T5: backpressure while LOCKED
    do_reset();
    force_busy = 1'b1;
    req_push(2, 8'hC3, 1'b1);
    exp_push(2, 8'hC3);
    @(negedge clk);
    check("t5_grant_active", 32'(grant_active), 32'd1);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (req_ready !== '0 || tx_start !== 1'b0) ok = 1'b0;
    end
    check("t5_held_off", 32'(ok), 32'd1);
    check("t5_sb_pending", 32'(exp_q.size()), 32'd1);
    force_busy = 1'b0;
    wait_idle("t5", 200);

    // T6: owner drops valid mid-message
    do_reset();
    req_push(1, 8'hA5, 1'b0);
    req_push(3, 8'h33, 1'b1);
    exp_push(1, 8'hA5);
    c = 0;
    while (tx_start !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    check("t6_first_start", 32'(c < 50), 32'd1);
    c = 0;
    while (tx_busy !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    while (tx_busy !== 1'b0 && c < 50) begin @(negedge clk); c++; end
    check("t6_busy_done", 32'(c < 50), 32'd1);
`ifdef ARB_TIMEOUT_EN
    exp_push(3, 8'h33);
    c = 0;
    while (grant_active === 1'b1 && c < 100) begin @(negedge clk); c++; end
    check("t6_release_window", 32'(c >= TMO && c <= TMO + 4), 32'd1);
    wait_idle("t6", 200);
`else
    ok = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (grant_active !== 1'b1 || grant_id !== 2'd1) ok = 1'b0;
    end
    check("t6_grant_held", 32'(ok), 32'd1);
    req_push(1, 8'h0A, 1'b1);
    exp_push(1, 8'h0A);
    exp_push(3, 8'h33);
    wait_idle("t6", 400);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
